// File: rtl/gol_pkg.sv
// Shared constants for the Game-of-Life bank datapath: grid geometry,
// read-FIFO sizing and the bank reader FSM encoding.
package gol_pkg;

    localparam int ADDR_W        = 16;
    localparam int DATA_W        = 4;
    localparam int GRID_DIM      = 256;
    localparam int RD_FIFO_DEPTH = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/gol_rd_fifo.sv
// Small synchronous FIFO with a combinational head; push and pop in the
// same cycle both take effect. DEPTH must be a power of two.
module gol_rd_fifo
    import gol_pkg::*;
#(
    parameter int DEPTH = RD_FIFO_DEPTH,
    parameter int WIDTH = ADDR_W + DATA_W,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [CNT_W-1:0] o_count,
    output logic [WIDTH-1:0] o_head
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/gol_bank_reader.sv
// Streams a full cell bank out of a 1-cycle-latency RAM as ordered
// (x, y, data) beats with valid/ready flow control.
module gol_bank_reader
    import gol_pkg::*;
#(
    parameter int ADDR_W = gol_pkg::ADDR_W,
    parameter int DATA_W = gol_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_re,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              cell_valid,
    input  logic              cell_ready,
    output logic [DATA_W-1:0] cell_data,
    output logic [7:0]        cell_x,
    output logic [7:0]        cell_y,
    output logic              cell_last
);

    localparam int CNT_W = $clog2(RD_FIFO_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;
    localparam int ENT_W = ADDR_W + DATA_W;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_rd_vld;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_done;

    logic [CNT_W-1:0]  w_count;
    logic [ENT_W-1:0]  w_head;
    logic [ADDR_W-1:0] w_head_addr;
    logic [OCC_W-1:0]  w_occ;
    logic              w_issue;
    logic              w_last_issue;
    logic              w_pop;

    // Issue only sees registered occupancy, so cell_ready never reaches the RAM port.
    assign w_occ        = {1'b0, w_count} + {{CNT_W{1'b0}}, r_rd_vld};
    assign w_issue      = (r_state == ST_RUN) && (w_occ <= OCC_W'(RD_FIFO_DEPTH - 1));
    assign w_last_issue = w_issue && (r_cnt == {ADDR_W{1'b1}});

    assign cell_valid  = (w_count != '0);
    assign w_pop       = cell_valid && cell_ready;
    assign w_head_addr = w_head[ENT_W-1:DATA_W];
    assign cell_data   = w_head[DATA_W-1:0];
    assign cell_x      = w_head_addr[7:0];
    assign cell_y      = w_head_addr[15:8];
    assign cell_last   = cell_valid && (w_head_addr == {ADDR_W{1'b1}});

    assign ram_re   = w_issue;
    assign ram_addr = r_cnt;
    assign busy     = (r_state != ST_IDLE);
    assign done     = r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_rd_vld  <= 1'b0;
            r_rd_addr <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_rd_vld <= w_issue;
            if (w_issue) r_rd_addr <= r_cnt;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_RUN;
                        r_cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    // The counter parks on the final address so ram_addr holds in DRAIN.
                    if (w_last_issue)  r_state <= ST_DRAIN;
                    else if (w_issue)  r_cnt   <= r_cnt + ADDR_W'(1);
                end
                ST_DRAIN: begin
                    if (w_pop && cell_last) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    gol_rd_fifo #(
        .DEPTH (RD_FIFO_DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_rd_vld),
        .i_wdata ({r_rd_addr, ram_rdata}),
        .i_pop   (w_pop),
        .o_count (w_count),
        .o_head  (w_head)
    );

endmodule

// File: tb/tb_gol_bank_reader.sv
// Randomized bench for gol_bank_reader: a 1-cycle RAM holding addr[3:0] and
// a reference that tracks the ordered address stream with plain counters.
module tb_gol_bank_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic [15:0] ram_addr;
    logic        ram_re;
    logic [3:0]  ram_rdata;
    logic        cell_valid;
    logic        cell_ready;
    logic [3:0]  cell_data;
    logic [7:0]  cell_x;
    logic [7:0]  cell_y;
    logic        cell_last;

    always #5 clk = ~clk;

    gol_bank_reader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .ram_addr   (ram_addr),
        .ram_re     (ram_re),
        .ram_rdata  (ram_rdata),
        .cell_valid (cell_valid),
        .cell_ready (cell_ready),
        .cell_data  (cell_data),
        .cell_x     (cell_x),
        .cell_y     (cell_y),
        .cell_last  (cell_last)
    );

    always @(posedge clk) begin
        if (ram_re) ram_rdata <= ram_addr[3:0];
    end

    int          err_cnt = 0;
    int          chk_cnt = 0;
    int          cyc     = 0;
    int          t0      = 0;
    int          exp_rd, issued, beats, dones, done_cyc;
    bit          mon_en  = 1'b0;
    bit          seen_first, prev_stall, pulsed;
    logic [20:0] prev_snap;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic ref_clear();
        exp_rd = 0; issued = 0; beats = 0; dones = 0; done_cyc = -1;
        seen_first = 1'b0; prev_stall = 1'b0;
    endtask

    function automatic logic [20:0] exp_beat(input int b);
        logic [3:0] d;
        logic [7:0] x;
        logic [7:0] y;
        d = 4'(b % 16);
        x = 8'(b % 256);
        y = 8'(b / 256);
        return {d, x, y, (b == 65535)};
    endfunction

    // Evaluates what happens at the coming edge with this cycle's final inputs.
    task automatic account();
        if (!mon_en || rst) begin
            prev_stall = 1'b0;
            return;
        end
        if (prev_stall)
            chk("head_stable", {cell_valid, cell_data, cell_x, cell_y, cell_last}, {1'b1, prev_snap});
        if (ram_re) begin
            if (exp_rd == 0) chk("rd_latency", cyc, t0 + 1);
            chk("rd_addr", 32'(ram_addr), exp_rd);
            exp_rd++;
            issued++;
            chk("occupancy_le4", 32'(issued - beats <= 4), 1);
        end
        if (cell_valid && !seen_first) begin
            seen_first = 1'b1;
            chk("first_valid", cyc, t0 + 3);
        end
        if (cell_valid && cell_ready) begin
            chk("beat", {cell_data, cell_x, cell_y, cell_last}, exp_beat(beats));
            beats++;
        end
        if (done) begin
            dones++;
            done_cyc = cyc;
            chk("busy_at_done", 32'(busy), 0);
        end
        prev_stall = cell_valid && !cell_ready;
        prev_snap  = {cell_data, cell_x, cell_y, cell_last};
    endtask

    task automatic tick();
        account();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cell_ready = 1'b0;
        repeat (3) tick();
        chk("rst_busy",   32'(busy), 0);
        chk("rst_done",   32'(done), 0);
        chk("rst_ram_re", 32'(ram_re), 0);
        chk("rst_addr",   32'(ram_addr), 0);
        chk("rst_valid",  32'(cell_valid), 0);
        chk("rst_last",   32'(cell_last), 0);
        rst = 1'b0;
        tick();
        ref_clear();
        mon_en = 1'b1;

        // reset and start together: reset wins
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        chk("rs_busy", 32'(busy), 0);
        chk("rs_re",   32'(ram_re), 0);
        tick();
        chk("rs_re2",  32'(ram_re), 0);
        chk("rs_busy2", 32'(busy), 0);

        // full scan at full rate, with an ignored start at beat 1000
        ref_clear();
        pulsed = 1'b0;
        cell_ready = 1'b1;
        t0 = cyc; start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_run", 32'(busy), 1);
        for (int i = 0; i < 66000 && dones == 0; i++) begin
            if (beats == 1000 && !pulsed) begin
                start = 1'b1; pulsed = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        repeat (10) tick();
        chk("full_done_cnt", dones, 1);
        chk("full_done_cyc", done_cyc, t0 + 65539);
        chk("full_beats",    beats, 65536);
        chk("full_reads",    issued, 65536);
        chk("idle_busy",     32'(busy), 0);

        // random 30% ready, reset mid-scan at beat 500
        ref_clear();
        cell_ready = 1'b0;
        t0 = cyc; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6000 && beats < 500; i++) begin
            cell_ready = ($urandom_range(0, 9) < 3);
            tick();
        end
        chk("rnd_beats", beats, 500);
        cell_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_valid", 32'(cell_valid), 0);
        chk("abort_re",    32'(ram_re), 0);
        chk("abort_busy",  32'(busy), 0);
        chk("abort_done",  32'(done), 0);
        ref_clear();
        repeat (6) tick();
        chk("abort_no_done", dones, 0);
        chk("abort_no_beat", beats, 0);

        // restart with downstream stalled: exactly four reads, then resume
        ref_clear();
        cell_ready = 1'b0;
        t0 = cyc; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (100) tick();
        chk("stall_reads", issued, 4);
        chk("stall_re",    32'(ram_re), 0);
        chk("stall_valid", 32'(cell_valid), 1);
        cell_ready = 1'b1;
        repeat (40) tick();
        chk("resume_beats", beats, 40);
        chk("resume_reads", 32'(issued > 40), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mon_en = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
